k051962_layer_shift: RTL and testbench

K051962_LAYER_SHIFT -- requirements
Module: k051962_layer_shift

---
 rtl/k051962_pkg.sv | 27 ++
 rtl/k051962_delay_line.sv | 48 ++++
 rtl/k051962_layer_shift.sv | 96 +++++++++
 tb/tb_k051962_layer_shift.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/k051962_pkg.sv
// Shared widths, the serializer pixel-word type and a nibble-order helper
// for the K051962 layer shift stage.
package k051962_pkg;

    localparam int PIX_W       = 4;
    localparam int ATTR_W      = 8;
    localparam int DELAY_DEPTH = 7;
    localparam int TILE_PIX    = 8;
    localparam int WORD_W      = PIX_W + ATTR_W;
    localparam int SR_W        = PIX_W * TILE_PIX;
    localparam int FINE_W      = 3;

    // One serialized pixel: {pixel index, colour attribute}
    typedef logic [WORD_W-1:0] pix_word_t;

    // Reverse the order of the 4-bit pixels inside a tile row so that the
    // last pixel ends up in the most significant nibble (shifted out first).
    function automatic logic [SR_W-1:0] nibble_reverse(input logic [SR_W-1:0] d);
        logic [SR_W-1:0] r;
        r = '0;
        for (int i = 0; i < TILE_PIX; i++) begin
            r[i*PIX_W +: PIX_W] = d[(TILE_PIX-1-i)*PIX_W +: PIX_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/k051962_delay_line.sv
// Pixel-rate delay line D1..Dn with a tap mux. Tap 0 returns the live
// input word, tap k returns the word that entered k strobes ago.
module k051962_delay_line #(
    parameter int DELAY_DEPTH = k051962_pkg::DELAY_DEPTH,
    parameter int TAP_W       = $clog2(DELAY_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    pixel_en,
    input  k051962_pkg::pix_word_t  word,
    input  logic [TAP_W-1:0]        tap,
    output k051962_pkg::pix_word_t  tap_word
);

    // tap_src[0] is the live word, tap_src[k] is stage Dk
    k051962_pkg::pix_word_t tap_src [0:DELAY_DEPTH];

    assign tap_src[0] = word;

    genvar gi;
    generate
        for (gi = 1; gi <= DELAY_DEPTH; gi++) begin : g_stage
            k051962_pkg::pix_word_t d_reg;

            // Each stage advances by one position per pixel strobe
            always_ff @(posedge clk) begin
                if (srst) begin
                    d_reg <= '0;
                end else if (pixel_en) begin
                    d_reg <= tap_src[gi-1];
                end
            end

            assign tap_src[gi] = d_reg;
        end
    endgenerate

    // Select the requested delay; out-of-range taps fall back to the live word
    always_comb begin
        tap_word = word;
        for (int i = 1; i <= DELAY_DEPTH; i++) begin
            if (tap == TAP_W'(i)) begin
                tap_word = tap_src[i];
            end
        end
    end

endmodule

// File: rtl/k051962_layer_shift.sv
// K051962 tile-layer pixel serializer: loads a 32-bit tile row, shifts it
// out one 4-bit pixel per strobe, and delays the stream by the fine X
// scroll before registering pixel, colour and opacity.
module k051962_layer_shift
    import k051962_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PIXEL_EN,
    input  logic              LOAD,
    input  logic [SR_W-1:0]   ROM_DATA,
    input  logic [ATTR_W-1:0] ATTR,
    input  logic              FLIP_X,
    input  logic [FINE_W-1:0] FINE,
    output logic [PIX_W-1:0]  PIXEL,
    output logic [ATTR_W-1:0] COLOR,
    output logic              OPAQUE
);

    logic [SR_W-1:0]   sr_reg,     sr_next;
    logic [ATTR_W-1:0] attr_reg,   attr_next;
    logic [FINE_W-1:0] fine_reg,   fine_next;
    logic [PIX_W-1:0]  pixel_reg,  pixel_next;
    logic [ATTR_W-1:0] color_reg,  color_next;
    logic              opaque_reg, opaque_next;

    pix_word_t serial_word;
    pix_word_t tap_word;

    // Current serializer output: leading nibble of the row plus the tile attribute
    assign serial_word = {sr_reg[SR_W-1 -: PIX_W], attr_reg};

    k051962_delay_line #(
        .DELAY_DEPTH (DELAY_DEPTH),
        .TAP_W       (FINE_W)
    ) u_delay_line (
        .clk      (CLK),
        .srst     (RESET),
        .pixel_en (PIXEL_EN),
        .word     (serial_word),
        .tap      (fine_reg),
        .tap_word (tap_word)
    );

    // Serializer next state: reload at the group boundary, otherwise shift with zero fill
    always_comb begin
        sr_next   = sr_reg;
        attr_next = attr_reg;
        fine_next = fine_reg;
        if (PIXEL_EN) begin
            if (LOAD) begin
                sr_next   = FLIP_X ? nibble_reverse(ROM_DATA) : ROM_DATA;
                attr_next = ATTR;
                fine_next = FINE;
            end else begin
                sr_next = {sr_reg[SR_W-PIX_W-1:0], {PIX_W{1'b0}}};
            end
        end
    end

    // Output next state: the delayed word chosen by the fine scroll latched at the last load
    always_comb begin
        pixel_next  = pixel_reg;
        color_next  = color_reg;
        opaque_next = opaque_reg;
        if (PIXEL_EN) begin
            pixel_next  = tap_word[WORD_W-1 -: PIX_W];
            color_next  = tap_word[ATTR_W-1:0];
            opaque_next = |tap_word[WORD_W-1 -: PIX_W];
        end
    end

    // All state registers; reset discards any in-flight pixels
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sr_reg     <= '0;
            attr_reg   <= '0;
            fine_reg   <= '0;
            pixel_reg  <= '0;
            color_reg  <= '0;
            opaque_reg <= 1'b0;
        end else begin
            sr_reg     <= sr_next;
            attr_reg   <= attr_next;
            fine_reg   <= fine_next;
            pixel_reg  <= pixel_next;
            color_reg  <= color_next;
            opaque_reg <= opaque_next;
        end
    end

    assign PIXEL  = pixel_reg;
    assign COLOR  = color_reg;
    assign OPAQUE = opaque_reg;

endmodule

// File: tb/tb_k051962_layer_shift.sv
// Bench for the K051962 layer shift stage: directed tile scenarios plus a
// randomized run, checked every cycle against a pixel-stream reference model.
module tb_k051962_layer_shift;

    logic        CLK;
    logic        RESET;
    logic        PIXEL_EN;
    logic        LOAD;
    logic [31:0] ROM_DATA;
    logic [7:0]  ATTR;
    logic        FLIP_X;
    logic [2:0]  FINE;
    logic [3:0]  PIXEL;
    logic [7:0]  COLOR;
    logic        OPAQUE;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    k051962_layer_shift dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PIXEL_EN (PIXEL_EN),
        .LOAD     (LOAD),
        .ROM_DATA (ROM_DATA),
        .ATTR     (ATTR),
        .FLIP_X   (FLIP_X),
        .FINE     (FINE),
        .PIXEL    (PIXEL),
        .COLOR    (COLOR),
        .OPAQUE   (OPAQUE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: the tile currently being emitted, how many pixels of
    // it have gone out, and the history of emitted pixel words (newest first).
    logic [3:0]  m_pix [8];
    logic [7:0]  m_attr;
    logic [2:0]  m_fine;
    int          m_idx;
    logic [11:0] m_hist [8];
    logic [3:0]  exp_pix;
    logic [7:0]  exp_col;
    logic        exp_opq;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_pix[i]  = 4'h0;
            m_hist[i] = 12'h000;
        end
        m_attr  = 8'h00;
        m_fine  = 3'd0;
        m_idx   = 8;
        exp_pix = 4'h0;
        exp_col = 8'h00;
        exp_opq = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model, then check after the edge
    task automatic cycle(input bit rst, input bit en, input bit ld, input logic [31:0] rom,
                         input logic [7:0] at, input bit fl, input logic [2:0] fn);
        logic [11:0] w;
        logic [3:0]  p;
        RESET    = rst;
        PIXEL_EN = en;
        LOAD     = ld;
        ROM_DATA = rom;
        ATTR     = at;
        FLIP_X   = fl;
        FINE     = fn;
        if (rst) begin
            model_clear();
        end else if (en) begin
            p = (m_idx < 8) ? m_pix[m_idx] : 4'h0;
            w = {p, m_attr};
            for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = w;
            exp_pix = m_hist[m_fine][11:8];
            exp_col = m_hist[m_fine][7:0];
            exp_opq = (m_hist[m_fine][11:8] != 4'h0);
            if (ld) begin
                for (int i = 0; i < 8; i++) begin
                    m_pix[i] = fl ? rom[4*i +: 4] : rom[31-4*i -: 4];
                end
                m_attr = at;
                m_fine = fn;
                m_idx  = 0;
            end else if (m_idx < 8) begin
                m_idx++;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
        $display("cyc %0d rst=%0b en=%0b ld=%0b pix=%h col=%h opq=%0b exp=%h/%h/%0b",
                 cyc, rst, en, ld, PIXEL, COLOR, OPAQUE, exp_pix, exp_col, exp_opq);
        chk("pixel", 32'(PIXEL), 32'(exp_pix));
        chk("color", 32'(COLOR), 32'(exp_col));
        chk("opaque", 32'(OPAQUE), 32'(exp_opq));
    endtask

    initial begin
        model_clear();
        RESET = 1'b1; PIXEL_EN = 1'b0; LOAD = 1'b0;
        ROM_DATA = '0; ATTR = '0; FLIP_X = 1'b0; FINE = '0;

        // Reset state, with strobe and load asserted to prove reset wins
        cycle(1, 0, 0, 32'h0, 8'h00, 0, 3'd0);
        cycle(1, 1, 1, 32'hFFFF_FFFF, 8'hFF, 0, 3'd5);
        chk("rst_pix", 32'(PIXEL), 32'h0);
        chk("rst_col", 32'(COLOR), 32'h0);

        // Straight tile, fine 0: pixels 0..7 on strobes t0+1..t0+8
        cycle(0, 1, 1, 32'h0123_4567, 8'h5A, 0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, (k == 7), 32'h0123_4567, 8'h5A, 1, 3'd0);
            chk("r018_pix", 32'(PIXEL), 32'(k));
            chk("r018_col", 32'(COLOR), 32'h5A);
            chk("r018_opq", 32'(OPAQUE), (k != 0) ? 32'h1 : 32'h0);
        end

        // Flipped tile: pixels 7..0
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, (k == 7), 32'h0123_4567, 8'h5A, 0, 3'd3);
            chk("r019_pix", 32'(PIXEL), 32'(7 - k));
        end

        // Fine 3 with back-to-back loads: pixel 0 at t0+4, next tile contiguous
        for (int k = 0; k < 16; k++) begin
            if (k == 7)
                cycle(0, 1, 1, 32'h89AB_CDEF, 8'h33, 0, 3'd3);
            else
                cycle(0, 1, (k == 15), 32'h0123_4567, 8'h5A, 0, 3'd0);
            if (k >= 3 && k <= 10) begin
                chk("r020_pix_a", 32'(PIXEL), 32'(k - 3));
                chk("r020_col_a", 32'(COLOR), 32'h5A);
            end
            if (k >= 11) begin
                chk("r020_pix_b", 32'(PIXEL), 32'(k - 3));
                chk("r020_col_b", 32'(COLOR), 32'h33);
            end
        end

        // Strobe every 4th cycle: same sequence, outputs hold between strobes
        for (int s = 0; s < 8; s++) begin
            for (int j = 0; j < 3; j++) begin
                cycle(0, 0, 1'($urandom), $urandom, 8'($urandom), 1'($urandom), 3'($urandom));
                if (s > 0) chk("r021_hold", 32'(PIXEL), 32'(s - 1));
            end
            cycle(0, 1, (s == 7), 32'h0123_4567, 8'h77, 0, 3'd2);
            chk("r021_pix", 32'(PIXEL), 32'(s));
        end

        // Reset mid-tile: outputs zero until a fresh load propagates
        for (int k = 0; k < 6; k++) cycle(0, 1, 0, 32'h0, 8'h00, 0, 3'd0);
        cycle(1, 1, 0, 32'h0, 8'h00, 0, 3'd0);
        chk("r022_rst_pix", 32'(PIXEL), 32'h0);
        chk("r022_rst_col", 32'(COLOR), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 0, 32'h0, 8'h00, 0, 3'd0);
            chk("r022_zero", {20'h0, PIXEL, COLOR}, 32'h0);
        end
        cycle(0, 1, 1, 32'hFEDC_BA98, 8'h66, 0, 3'd1);
        for (int k = 0; k < 9; k++) cycle(0, 1, (k == 8), 32'h1357_9BDF, 8'h11, 0, 3'd7);

        // Fine 7 across a tile boundary: each pixel keeps its own tile's colour
        for (int k = 0; k < 24; k++) begin
            if (k == 7)
                cycle(0, 1, 1, 32'h2468_ACE1, 8'h22, 0, 3'd7);
            else
                cycle(0, 1, (k == 15), $urandom, 8'h44, 1'($urandom), 3'd7);
            if (k >= 7 && k <= 14) chk("r023_col_a", 32'(COLOR), 32'h11);
            if (k >= 15 && k <= 22) chk("r023_col_b", 32'(COLOR), 32'h22);
        end

        // More than 7 shifts without load: pixel 0 with the last attribute
        for (int k = 0; k < 10; k++) cycle(0, 1, 0, 32'h0, 8'h00, 0, 3'd0);
        chk("r013_pix", 32'(PIXEL), 32'h0);
        chk("r013_col", 32'(COLOR), 32'h44);

        // Randomized traffic including early loads and occasional resets
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom % 60) == 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
                  $urandom, 8'($urandom), 1'($urandom), 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
